fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch front end of the 5-stage RV32I pipeline: owns the fetch PC and issues word reads to instruction memory over a request/grant/response handshake with variable latency. It buffers returned instructions and drives the IF/ID pipeline register. It consumes StallF, StallD and FlushD from the hazard unit, and PCSrcE/PCTargetE from Execute. Memory latency is absorbed here, so decode sees either a valid instruction or a NOP bubble.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- FIFO_DEPTH, 2, instruction buffer entries; also the cap on buffered plus in-flight reads
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- StallF  in  1  hazard unit: block new fetch requests
- StallD  in  1  hazard unit: hold IF/ID register
- FlushD  in  1  hazard unit: load bubble into IF/ID register
- PCSrcE  in  1  Execute: taken branch/jump redirect
- PCTargetE  in  32  Execute: redirect target
- imem_req  out  1  read request
- imem_addr  out  32  read address (= PCF, bits [1:0] always 0)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid (in order, ≥1 cycle after grant)
- imem_rdata  in  32  read data
- InstrD  out  32  decode-stage instruction
- PCD  out  32  PC of InstrD
- PCPlus4D  out  32  PCD + 4
- ValidD  out  1  InstrD is a real instruction (0 = bubble)

## Operation
- Issue: imem_req = !rst_state && !StallF && !PCSrcE && (fifo_count + outstanding < FIFO_DEPTH). A handshake is imem_req && imem_gnt. On a handshake, PCF <= PCF + 4 (32-bit wrap) and outstanding increments.
- Epoch: a 1-bit epoch is pushed into an in-order tag queue on each handshake. On imem_rvalid, the tag pops and outstanding decrements. The response is kept only if its tag equals the current epoch; otherwise it is dropped silently.
- Redirect (PCSrcE=1): PCF <= {PCTargetE[31:2],2'b00}, epoch toggles, instruction FIFO cleared, IF/ID register loaded with a bubble. PCSrcE takes priority over StallF, StallD and a simultaneous grant; any grant in that cycle is impossible because imem_req=0.
- Responses arriving in the redirect cycle are stale and dropped.
- Keep path: a kept response carries {instr, pc}, where pc is recorded per entry in the tag queue. It goes to the FIFO, or bypasses to IF/ID (below).
- IF/ID update, in priority order:
  1. FlushD or PCSrcE → InstrD=NOP, ValidD=0, PCD/PCPlus4D unchanged.
  2. StallD → hold.
  3. FIFO non-empty → pop into IF/ID, ValidD=1.
  4. FIFO empty and kept response this cycle → bypass into IF/ID, ValidD=1.
  5. Otherwise → bubble.
- While StallD holds, a kept response is written to the FIFO. The credit rule guarantees it never overflows.
- imem_rvalid with outstanding=0 is a protocol violation: ignored, flagged by assertion.

## Timing
- Reset values: PCF=RESET_PC, imem_req=0, imem_addr=RESET_PC, InstrD=32'h0000_0013, PCD=0, PCPlus4D=4, ValidD=0, epoch=0, FIFO/tag queue empty, outstanding=0.
- First imem_req is in the first cycle after rst deasserts.
- Reset mid-operation discards all state immediately. Instruction memory shares rst, so no stale response follows.
- Latency: grant in cycle N, rvalid in cycle N+L → InstrD valid after the clk edge ending cycle N+L (bypass path), with no added cycle.
- Throughput: with L=1 and gnt tied high, one instruction per cycle sustained with FIFO_DEPTH=2.
- Redirect: PCSrcE in cycle R → imem_addr=target in R+1, first target instruction at InstrD no earlier than R+1+L.

## Structure
- Package fetch_pkg holds:
  - NOP constant 32'h0000_0013
  - fetch_entry_t struct {logic [31:0] instr; logic [31:0] pc;}
  - tag entry struct {logic epoch; logic [31:0] pc;}
- One sub-module, fetch_fifo: a parameterised synchronous FIFO (type/width and depth parameters, push/pop/clear, count output).
  - Instantiated twice: instruction buffer and tag queue.
- Top level holds PCF, the epoch and outstanding counters, and the IF/ID register.

## Test plan
- Reset release, gnt=1, L=1, memory returns addr-derived words → PCD sequence 0,4,8,…, one per cycle, ValidD=1 from cycle 2.
- L=3 with gnt=1 → outstanding never exceeds 2; imem_req drops at fifo_count+outstanding=2; no instruction lost or duplicated.
- StallD held 4 cycles mid-stream → InstrD/PCD frozen, FIFO fills to 2, imem_req=0; on release PCD resumes at the next sequential PC.
- PCSrcE=1 with PCTargetE=0x100 while two reads are in flight (L=2) → both stale responses dropped, next ValidD=1 instruction has PCD=0x100.
- PCSrcE=1 and StallF=1 in the same cycle with PCTargetE=0x203 → imem_addr=0x200 next cycle, redirect wins, IF/ID bubble.
- rst asserted mid-stream for 1 cycle → all outputs return to reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the RV32I instruction-fetch front end.
// Buffer entries and in-flight tags carry their own PC.
package fetch_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef struct packed {
    logic        epoch;
    logic [31:0] pc;
  } tag_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear and occupancy count.
// Used for both the instruction buffer and the in-flight tag queue.
module fetch_fifo #(
  parameter type T = logic [31:0],
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  T              wdata,
  output T              rdata,
  output logic [CW-1:0] count
);

  T mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic do_push;
  logic do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch PC, credit-limited imem requests, epoch-tagged responses
// and the IF/ID register with a zero-latency bypass.
module fetch_stage import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   pcf;
  logic          epoch;
  logic [CW-1:0] icount;
  logic [CW-1:0] tcount;
  tag_entry_t    tag_in;
  tag_entry_t    tag_out;
  fetch_entry_t  ent_in;
  fetch_entry_t  ent_out;
  logic hs, rsp, keep, flush;
  logic pop_i, byp, push_i;
  logic unused_lsb;

  assign unused_lsb = ^PCTargetE[1:0];

  // Credits cover both buffered and in-flight words
  assign imem_req = !rst && !StallF && !PCSrcE
                 && (int'(icount) + int'(tcount) < FIFO_DEPTH);
  assign imem_addr = pcf;
  assign hs = imem_req && imem_gnt;

  assign rsp  = imem_rvalid && (tcount != '0);
  assign keep = rsp && (tag_out.epoch == epoch) && !PCSrcE;

  assign flush  = FlushD || PCSrcE;
  assign pop_i  = !flush && !StallD && (icount != '0);
  assign byp    = !flush && !StallD && (icount == '0) && keep;
  assign push_i = keep && !byp;

  assign tag_in = '{epoch: epoch, pc: pcf};
  assign ent_in = '{instr: imem_rdata, pc: tag_out.pc};

  fetch_fifo #(.T(tag_entry_t), .DEPTH(FIFO_DEPTH)) u_tagq (
    .clk(clk), .rst(rst),
    .push(hs), .pop(rsp), .clear(1'b0),
    .wdata(tag_in), .rdata(tag_out), .count(tcount)
  );

  fetch_fifo #(.T(fetch_entry_t), .DEPTH(FIFO_DEPTH)) u_ibuf (
    .clk(clk), .rst(rst),
    .push(push_i), .pop(pop_i), .clear(PCSrcE),
    .wdata(ent_in), .rdata(ent_out), .count(icount)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf   <= RESET_PC;
      epoch <= 1'b0;
    end else if (PCSrcE) begin
      pcf   <= {PCTargetE[31:2], 2'b00};
      epoch <= ~epoch;
    end else if (hs) begin
      pcf <= pcf + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= 32'd4;
      ValidD   <= 1'b0;
    end else if (flush) begin
      InstrD <= NOP;
      ValidD <= 1'b0;
    end else if (StallD) begin
      ValidD <= ValidD;
    end else if (pop_i) begin
      InstrD   <= ent_out.instr;
      PCD      <= ent_out.pc;
      PCPlus4D <= ent_out.pc + 32'd4;
      ValidD   <= 1'b1;
    end else if (byp) begin
      InstrD   <= imem_rdata;
      PCD      <= tag_out.pc;
      PCPlus4D <= tag_out.pc + 32'd4;
      ValidD   <= 1'b1;
    end else begin
      InstrD <= NOP;
      ValidD <= 1'b0;
    end
  end

  rvalid_orphan: assert property (
    @(posedge clk) disable iff (rst) !(imem_rvalid && (tcount == '0)));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model plus a PC
// scoreboard checked whenever decode consumes an instruction.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic StallF = 1'b1;
  logic StallD = 1'b0;
  logic FlushD = 1'b0;
  logic PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_gnt = 1'b1;
  logic imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic ValidD;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cyc = 0;
  logic [31:0] sb_e;

  typedef struct {
    logic [31:0] addr;
    int due;
  } pend_t;

  pend_t pend[$];
  logic [31:0] exp_q[$];

  fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h0000_9E37) + 32'h33;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 0);
    repeat (3) step();
  endtask

  // Memory: fixed latency, responses in order
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      imem_rvalid = 1'b0;
      pend.delete();
    end else if (pend.size() != 0 && pend[0].due == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (imem_rvalid) void'(pend.pop_front());
      if (imem_req && imem_gnt) pend.push_back('{imem_addr, cyc + lat});
    end
  end

  // Monitor: decode consumes InstrD when valid and not stalled
  always @(negedge clk) begin
    if (!rst && ValidD && !StallD) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got PCD %h expected none", PCD);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_pcd", PCD, sb_e);
        check("sb_instr", InstrD, word(sb_e));
        check("sb_pc4", PCPlus4D, sb_e + 32'd4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_instr", InstrD, NOP);
    check("rst_pcd", PCD, 0);
    check("rst_pc4", PCPlus4D, 4);
    check("rst_valid", ValidD, 0);

    // L=1 streaming, one per cycle
    step();
    rst = 1'b0;
    StallF = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    for (int c = 0; c <= 10; c++) begin
      if (c == 8) StallF = 1'b1;
      @(negedge clk);
      if (c == 0) begin
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 0);
      end
      check($sformatf("s1_valid_c%0d", c), ValidD, (c >= 2 && c <= 9));
      step();
    end
    drain(20);

    // L=3: credit limit of two
    lat = 3;
    StallF = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(32 + i * 4));
    for (int c = 0; c <= 12; c++) begin
      if (c == 12) StallF = 1'b1;
      @(negedge clk);
      if (c < 12)
        check($sformatf("s2_req_c%0d", c), imem_req, ((c % 4) < 2));
      step();
    end
    drain(30);

    // StallD for 4 cycles mid-stream
    lat = 1;
    StallF = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(56 + i * 4));
    for (int c = 0; c <= 10; c++) begin
      if (c == 2) StallD = 1'b1;
      if (c == 6) StallD = 1'b0;
      if (c == 10) StallF = 1'b1;
      @(negedge clk);
      if (c >= 2 && c <= 7) begin
        check($sformatf("s3_req_c%0d", c), imem_req, (c == 2 || c == 7));
        check($sformatf("s3_pcd_c%0d", c), PCD, (c == 7) ? 32'd60 : 32'd56);
      end
      step();
    end
    drain(20);

    // Redirect with two reads in flight
    lat = 2;
    StallF = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(32'h100 + i * 4));
    for (int c = 0; c <= 8; c++) begin
      if (c == 2) begin
        PCSrcE = 1'b1;
        PCTargetE = 32'h100;
      end
      if (c == 3) PCSrcE = 1'b0;
      if (c == 8) StallF = 1'b1;
      @(negedge clk);
      if (c == 2) check("s4_req_redirect", imem_req, 0);
      if (c == 3) begin
        check("s4_addr", imem_addr, 32'h100);
        check("s4_bubble", ValidD, 0);
      end
      if (c == 6) begin
        check("s4_valid", ValidD, 1);
        check("s4_pcd", PCD, 32'h100);
      end
      step();
    end
    drain(20);

    // Redirect together with StallF, unaligned target
    lat = 1;
    exp_q.push_back(32'h110);
    exp_q.push_back(32'h200);
    for (int c = 0; c <= 6; c++) begin
      if (c == 0) StallF = 1'b0;
      if (c == 1) StallF = 1'b1;
      if (c == 2) begin
        PCSrcE = 1'b1;
        PCTargetE = 32'h203;
      end
      if (c == 3) begin
        PCSrcE = 1'b0;
        StallF = 1'b0;
      end
      if (c == 4) StallF = 1'b1;
      @(negedge clk);
      if (c == 2) begin
        check("s5_valid_pre", ValidD, 1);
        check("s5_req", imem_req, 0);
      end
      if (c == 3) begin
        check("s5_addr", imem_addr, 32'h200);
        check("s5_bubble", ValidD, 0);
        check("s5_nop", InstrD, NOP);
        check("s5_pcd_kept", PCD, 32'h110);
      end
      if (c == 5) begin
        check("s5_valid", ValidD, 1);
        check("s5_pcd", PCD, 32'h200);
      end
      step();
    end
    drain(20);

    // Asynchronous reset mid-stream
    lat = 1;
    StallF = 1'b0;
    exp_q.push_back(32'h204);
    for (int c = 0; c < 3; c++) step();
    #2;
    rst = 1'b1;
    imem_rvalid = 1'b0;
    pend.delete();
    #1;
    check("s6_left", 32'(exp_q.size()), 0);
    check("s6_req", imem_req, 0);
    check("s6_addr", imem_addr, 0);
    check("s6_instr", InstrD, NOP);
    check("s6_pcd", PCD, 0);
    check("s6_pc4", PCPlus4D, 4);
    check("s6_valid", ValidD, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'(i * 4));
    for (int r = 0; r <= 3; r++) begin
      if (r == 3) StallF = 1'b1;
      @(negedge clk);
      if (r == 0) begin
        check("s6_restart_req", imem_req, 1);
        check("s6_restart_addr", imem_addr, 0);
      end
      step();
    end
    drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
